// File: rtl/mem_initiator.sv
// mem_initiator: CPU-side load/store bus master for the data-memory responder.
// Accepts one RISC-V load/store at a time, decodes funct3 into memSize/memSign,
// runs the memExecute/memReady/dataReady handshake and returns a one-cycle
// response (respValid/respErr/respData) to the pipeline.
//
// Build option: define MEM_TIMEOUT_EN to bound the time spent in WAIT
// (TIMEOUT_CYCLES) and add a DRAIN state that waits for the memory to go idle
// after a timeout. Without it, WAIT waits indefinitely.
module mem_initiator #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 8
) (
   input  logic        clk,
   input  logic        reset,
   // pipeline side
   input  logic        reqValid,
   output logic        reqReady,
   input  logic        reqWrite,
   input  logic [2:0]  reqFunct3,
   input  logic [31:0] reqAddress,
   input  logic [31:0] reqData,
   output logic        respValid,
   output logic [31:0] respData,
   output logic        respErr,
   // memory side
   input  logic        memReady,
   input  logic        dataReady,
   output logic        memExecute,
   output logic        memWrite,
   output logic [1:0]  memSize,
   output logic        memSign,
   output logic [31:0] memAddress,
   input  logic [31:0] outputData,
   output logic [31:0] inputData
);

   // The timeout counter must be able to hold TIMEOUT_CYCLES-1.
   if (((2 ** CNT_W) <= TIMEOUT_CYCLES) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
      $error("mem_initiator: CNT_W too narrow or TIMEOUT_CYCLES < 1");
   end

`ifdef MEM_TIMEOUT_EN
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      RESP  = 3'd3,
      DRAIN = 3'd4
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;
`endif

   state_t      state;
   state_t      state_next;

   logic        mem_execute_next;
   logic        mem_write_next;
   logic [1:0]  mem_size_next;
   logic        mem_sign_next;
   logic [31:0] mem_address_next;
   logic [31:0] input_data_next;
   logic        resp_valid_next;
   logic        resp_err_next;
   logic [31:0] resp_data_next;

`ifdef MEM_TIMEOUT_EN
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
`endif

   // Request decode, only meaningful in the acceptance cycle.
   logic req_accept;
   logic req_illegal;
   logic req_misaligned;
   logic load_done;

   assign reqReady   = (state == IDLE) && reset;
   assign req_accept = reqValid && reqReady;

   // Stores only have funct3 000/001/010; loads additionally have 100/101.
   assign req_illegal = reqWrite
                      ? (reqFunct3[2] || (reqFunct3[1:0] == 2'b11))
                      : ((reqFunct3[1:0] == 2'b11) || (reqFunct3 == 3'b110));

   assign req_misaligned = ((reqFunct3[1:0] == 2'b01) && reqAddress[0]) ||
                           ((reqFunct3[1:0] == 2'b10) && (reqAddress[1:0] != 2'b00));

   // A store finishes on memReady alone; a load also needs its read data.
   assign load_done = memReady && (memWrite || dataReady);

   // Next-state and next-output logic for the whole transaction sequence.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_next       = state;
      mem_execute_next = memExecute;
      mem_write_next   = memWrite;
      mem_size_next    = memSize;
      mem_sign_next    = memSign;
      mem_address_next = memAddress;
      input_data_next  = inputData;
      resp_valid_next  = 1'b0;
      resp_err_next    = respErr;
      resp_data_next   = respData;
`ifdef MEM_TIMEOUT_EN
      cnt_next         = cnt;
`endif

      case (state)
         IDLE: begin
            if (req_accept) begin
               // Latch the whole request; later changes on req* are ignored.
               mem_address_next = reqAddress;
               mem_write_next   = reqWrite;
               mem_size_next    = reqFunct3[1:0];
               mem_sign_next    = ~reqFunct3[2] & ~reqWrite;
               input_data_next  = reqData;
               if (req_illegal || req_misaligned) begin
                  // Rejected locally: no bus activity, error response next cycle.
                  state_next      = RESP;
                  resp_valid_next = 1'b1;
                  resp_err_next   = 1'b1;
                  resp_data_next  = 32'h0;
               end else begin
                  state_next       = ISSUE;
                  mem_execute_next = 1'b1;
               end
            end
         end

         ISSUE: begin
            // memReady falling is the only proof the memory took the request;
            // a memReady that is still high belongs to the previous idle period.
            if (!memReady) begin
               state_next       = WAIT;
               mem_execute_next = 1'b0;
`ifdef MEM_TIMEOUT_EN
               cnt_next         = '0;
`endif
            end
         end

         WAIT: begin
            if (load_done) begin
               state_next      = RESP;
               resp_valid_next = 1'b1;
               resp_err_next   = 1'b0;
               resp_data_next  = memWrite ? 32'h0 : outputData;
            end
`ifdef MEM_TIMEOUT_EN
            else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               // Last allowed WAIT cycle without completion: give up.
               state_next      = DRAIN;
               resp_valid_next = 1'b1;
               resp_err_next   = 1'b1;
               resp_data_next  = 32'h0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
`endif
         end

         RESP: begin
            state_next = IDLE;
         end

`ifdef MEM_TIMEOUT_EN
         DRAIN: begin
            // Let the abandoned transaction finish before accepting new work.
            if (memReady) begin
               state_next = IDLE;
            end
         end
`endif

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!reset) begin
         state      <= IDLE;
         memExecute <= 1'b0;
         memWrite   <= 1'b0;
         memSize    <= 2'b00;
         memSign    <= 1'b0;
         memAddress <= 32'h0;
         inputData  <= 32'h0;
         respValid  <= 1'b0;
         respErr    <= 1'b0;
         respData   <= 32'h0;
      end else begin
         state      <= state_next;
         memExecute <= mem_execute_next;
         memWrite   <= mem_write_next;
         memSize    <= mem_size_next;
         memSign    <= mem_sign_next;
         memAddress <= mem_address_next;
         inputData  <= input_data_next;
         respValid  <= resp_valid_next;
         respErr    <= resp_err_next;
         respData   <= resp_data_next;
      end
   end

`ifdef MEM_TIMEOUT_EN
   // WAIT-cycle counter for the timeout.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_next;
      end
   end
`endif

endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: table-driven check of mem_initiator against a behavioural
// model of the data-memory block (byte RAM plus LED register at 0x10000).
module tb_mem_initiator;

   logic        clk = 1'b0;
   logic        reset;
   logic        reqValid;
   logic        reqReady;
   logic        reqWrite;
   logic [2:0]  reqFunct3;
   logic [31:0] reqAddress;
   logic [31:0] reqData;
   logic        respValid;
   logic [31:0] respData;
   logic        respErr;
   logic        memReady;
   logic        dataReady;
   logic        memExecute;
   logic        memWrite;
   logic [1:0]  memSize;
   logic        memSign;
   logic [31:0] memAddress;
   logic [31:0] outputData;
   logic [31:0] inputData;

   int pass_cnt  = 0;
   int check_cnt = 0;

   mem_initiator #(
      .TIMEOUT_CYCLES(8),
      .CNT_W         (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .reqValid  (reqValid),
      .reqReady  (reqReady),
      .reqWrite  (reqWrite),
      .reqFunct3 (reqFunct3),
      .reqAddress(reqAddress),
      .reqData   (reqData),
      .respValid (respValid),
      .respData  (respData),
      .respErr   (respErr),
      .memReady  (memReady),
      .dataReady (dataReady),
      .memExecute(memExecute),
      .memWrite  (memWrite),
      .memSize   (memSize),
      .memSign   (memSign),
      .memAddress(memAddress),
      .outputData(outputData),
      .inputData (inputData)
   );

   always #5 clk = ~clk;

   // ---------------- memory model ----------------
   logic [7:0]  ram [0:4095];
   logic [31:0] led_reg;
   logic        mem_clear;
   logic        hold;
   int          acc_dly;
   int          mem_lat;
   logic        m_busy;
   int          acc_cnt;
   int          lat_cnt;
   logic [31:0] m_addr;
   logic [31:0] m_data;
   logic        m_write;
   logic [1:0]  m_size;
   logic        m_sign;

   function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [1:0] sz,
                                            input logic sg);
      logic [31:0] w;
      logic [11:0] i;
      i = a[11:0];
      if (a == 32'h0001_0000) w = led_reg;
      else w = {ram[i + 12'd3], ram[i + 12'd2], ram[i + 12'd1], ram[i]};
      case (sz)
         2'b00:   return sg ? {{24{w[7]}}, w[7:0]} : {24'h0, w[7:0]};
         2'b01:   return sg ? {{16{w[15]}}, w[15:0]} : {16'h0, w[15:0]};
         default: return w;
      endcase
   endfunction

   // Memory responder: accepts memExecute after acc_dly cycles (memReady falls),
   // completes mem_lat cycles later unless hold is set.
   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
         led_reg    <= 32'h0;
         memReady   <= 1'b1;
         dataReady  <= 1'b0;
         outputData <= 32'h0;
         m_busy     <= 1'b0;
         acc_cnt    <= 0;
         lat_cnt    <= 0;
      end else if (!m_busy) begin
         if (memExecute && memReady) begin
            if (acc_cnt < acc_dly) begin
               acc_cnt <= acc_cnt + 1;
            end else begin
               acc_cnt   <= 0;
               memReady  <= 1'b0;
               dataReady <= 1'b0;
               m_busy    <= 1'b1;
               lat_cnt   <= 0;
               m_addr    <= memAddress;
               m_data    <= inputData;
               m_write   <= memWrite;
               m_size    <= memSize;
               m_sign    <= memSign;
            end
         end
      end else if (!hold && lat_cnt >= mem_lat) begin
         m_busy   <= 1'b0;
         memReady <= 1'b1;
         if (m_write) begin
            dataReady <= 1'b0;
            if (m_addr == 32'h0001_0000) begin
               led_reg <= m_data;
            end else begin
               ram[m_addr[11:0]] <= m_data[7:0];
               if (m_size != 2'b00) ram[m_addr[11:0] + 12'd1] <= m_data[15:8];
               if (m_size == 2'b10) begin
                  ram[m_addr[11:0] + 12'd2] <= m_data[23:16];
                  ram[m_addr[11:0] + 12'd3] <= m_data[31:24];
               end
            end
         end else begin
            dataReady  <= 1'b1;
            outputData <= mem_read(m_addr, m_size, m_sign);
         end
      end else begin
         lat_cnt <= lat_cnt + 1;
      end
   end

   // ---------------- checking ----------------
   typedef struct {
      logic        write;
      logic [2:0]  funct3;
      logic [31:0] addr;
      logic [31:0] data;
      int          acc_dly;
      logic        exp_err;
      logic [31:0] exp_data;
      logic        exp_sign;
      logic [1:0]  exp_size;
      string       name;
   } vec_t;

   vec_t vecs [17];
   vec_t hv;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %08h expected %08h", name, act, exp);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (!(reqReady && memReady) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({name, "_ready"}, 32'(reqReady & memReady), 32'd1);
   endtask

   task automatic do_req(input vec_t v);
      int   n;
      logic exec_seen;
      wait_idle(v.name);
      acc_dly    = v.acc_dly;
      reqValid   = 1'b1;
      reqWrite   = v.write;
      reqFunct3  = v.funct3;
      reqAddress = v.addr;
      reqData    = v.data;
      @(negedge clk);
      // Scramble the request inputs; the DUT must have latched them already.
      reqValid   = 1'b0;
      reqWrite   = ~v.write;
      reqFunct3  = 3'b111;
      reqAddress = ~v.addr;
      reqData    = ~v.data;
      if (!v.exp_err) begin
         check({v.name, "_exec"}, 32'(memExecute), 32'd1);
         check({v.name, "_sign"}, 32'(memSign), 32'(v.exp_sign));
         check({v.name, "_size"}, 32'(memSize), 32'(v.exp_size));
         check({v.name, "_addr"}, memAddress, v.addr);
      end
      exec_seen = memExecute;
      n = 0;
      while (!respValid && n < 200) begin
         @(negedge clk);
         n++;
         exec_seen |= memExecute;
      end
      check({v.name, "_resp"}, 32'(respValid), 32'd1);
      check({v.name, "_err"}, 32'(respErr), 32'(v.exp_err));
      check({v.name, "_data"}, respData, v.exp_data);
      if (v.exp_err) begin
         check({v.name, "_err_lat"}, 32'(n), 32'd0);
         check({v.name, "_no_exec"}, 32'(exec_seen), 32'd0);
      end
      check({v.name, "_busy_rdy"}, 32'(reqReady), 32'd0);
      @(negedge clk);
      check({v.name, "_pulse"}, 32'(respValid), 32'd0);
   endtask

   task automatic start_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d);
      reqValid   = 1'b1;
      reqWrite   = w;
      reqFunct3  = f3;
      reqAddress = a;
      reqData    = d;
      @(negedge clk);
      reqValid   = 1'b0;
   endtask

   // Global bound so the run always ends.
   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic seen;

      //            wr    f3      addr          data          acc err  exp_data       sgn  sz
      vecs[0]  = '{1'b1, 3'b010, 32'h100,     32'hDEADBEEF, 0, 1'b0, 32'h00000000, 1'b0, 2'b10, "sw_100"};
      vecs[1]  = '{1'b0, 3'b010, 32'h100,     32'h0,        0, 1'b0, 32'hDEADBEEF, 1'b1, 2'b10, "lw_100"};
      vecs[2]  = '{1'b1, 3'b000, 32'h200,     32'h00000080, 0, 1'b0, 32'h00000000, 1'b0, 2'b00, "sb_200"};
      vecs[3]  = '{1'b0, 3'b000, 32'h200,     32'h0,        0, 1'b0, 32'hFFFFFF80, 1'b1, 2'b00, "lb_200"};
      vecs[4]  = '{1'b0, 3'b100, 32'h200,     32'h0,        0, 1'b0, 32'h00000080, 1'b0, 2'b00, "lbu_200"};
      vecs[5]  = '{1'b0, 3'b010, 32'h102,     32'h0,        0, 1'b1, 32'h00000000, 1'b0, 2'b00, "lw_mis"};
      vecs[6]  = '{1'b0, 3'b001, 32'h101,     32'h0,        0, 1'b1, 32'h00000000, 1'b0, 2'b00, "lh_mis"};
      vecs[7]  = '{1'b0, 3'b001, 32'h100,     32'h0,        3, 1'b0, 32'hFFFFBEEF, 1'b1, 2'b01, "lh_100"};
      vecs[8]  = '{1'b0, 3'b101, 32'h102,     32'h0,        0, 1'b0, 32'h0000DEAD, 1'b0, 2'b01, "lhu_102"};
      vecs[9]  = '{1'b0, 3'b011, 32'h100,     32'h0,        0, 1'b1, 32'h00000000, 1'b0, 2'b00, "ld_f3_011"};
      vecs[10] = '{1'b1, 3'b100, 32'h100,     32'h0,        0, 1'b1, 32'h00000000, 1'b0, 2'b00, "st_f3_100"};
      vecs[11] = '{1'b1, 3'b001, 32'h300,     32'h12345678, 0, 1'b0, 32'h00000000, 1'b0, 2'b01, "sh_300"};
      vecs[12] = '{1'b0, 3'b010, 32'h300,     32'h0,        1, 1'b0, 32'h00005678, 1'b1, 2'b10, "lw_300"};
      vecs[13] = '{1'b0, 3'b110, 32'h100,     32'h0,        0, 1'b1, 32'h00000000, 1'b0, 2'b00, "ld_f3_110"};
      vecs[14] = '{1'b1, 3'b000, 32'h103,     32'h00000011, 0, 1'b0, 32'h00000000, 1'b0, 2'b00, "sb_103"};
      vecs[15] = '{1'b0, 3'b010, 32'h100,     32'h0,        0, 1'b0, 32'h11ADBEEF, 1'b1, 2'b10, "lw_100b"};
      vecs[16] = '{1'b0, 3'b000, 32'h101,     32'h0,        0, 1'b0, 32'hFFFFFFBE, 1'b1, 2'b00, "lb_101"};

      reset      = 1'b0;
      mem_clear  = 1'b1;
      hold       = 1'b0;
      acc_dly    = 0;
      mem_lat    = 2;
      reqValid   = 1'b0;
      reqWrite   = 1'b0;
      reqFunct3  = 3'b000;
      reqAddress = 32'h0;
      reqData    = 32'h0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_reqReady", 32'(reqReady), 32'd0);
      check("rst_memExecute", 32'(memExecute), 32'd0);
      check("rst_respValid", 32'(respValid), 32'd0);
      check("rst_memSize", 32'(memSize), 32'd0);
      check("rst_memAddress", memAddress, 32'h0);
      mem_clear = 1'b0;
      reset     = 1'b1;
      @(negedge clk);
      check("idle_reqReady", 32'(reqReady), 32'd1);

      // Table-driven requests
      for (int i = 0; i < 17; i++) do_req(vecs[i]);

      // LED store: memExecute held while memory is not ready, drops the cycle
      // after memReady is sampled low.
      wait_idle("led");
      acc_dly = 2;
      start_req(1'b1, 3'b010, 32'h0001_0000, 32'h00000003);
      n = 0;
      while (memReady && n < 20) begin
         check("led_exec_hold", 32'(memExecute), 32'd1);
         @(negedge clk);
         n++;
      end
      check("led_memready_drop", 32'(memReady), 32'd0);
      check("led_exec_before", 32'(memExecute), 32'd1);
      @(negedge clk);
      check("led_exec_after", 32'(memExecute), 32'd0);
      n = 0;
      while (!respValid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("led_resp", 32'(respValid), 32'd1);
      check("led_err", 32'(respErr), 32'd0);
      check("led_data", respData, 32'h0);
      check("led_reg", led_reg, 32'h00000003);
      hv = '{1'b0, 3'b010, 32'h0001_0000, 32'h0, 0, 1'b0, 32'h00000003, 1'b1, 2'b10, "lw_led"};
      do_req(hv);

      // Reset pulled low during WAIT
      wait_idle("rstw");
      acc_dly = 0;
      hold    = 1'b1;
      start_req(1'b0, 3'b010, 32'h100, 32'h0);
      n = 0;
      while (memExecute && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rstw_wait_entry", 32'(memExecute), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rstw_reqReady", 32'(reqReady), 32'd0);
      check("rstw_memExecute", 32'(memExecute), 32'd0);
      check("rstw_memWrite", 32'(memWrite), 32'd0);
      check("rstw_memSign", 32'(memSign), 32'd0);
      check("rstw_memSize", 32'(memSize), 32'd0);
      check("rstw_memAddress", memAddress, 32'h0);
      check("rstw_inputData", inputData, 32'h0);
      check("rstw_respValid", 32'(respValid), 32'd0);
      check("rstw_respErr", 32'(respErr), 32'd0);
      check("rstw_respData", respData, 32'h0);
      hold = 1'b0;
      @(negedge clk);
      check("rstw_reqReady_low", 32'(reqReady), 32'd0);
      reset = 1'b1;
      seen  = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen |= respValid;
      end
      check("rstw_no_resp", 32'(seen), 32'd0);
      hv = '{1'b0, 3'b010, 32'h100, 32'h0, 0, 1'b0, 32'h11ADBEEF, 1'b1, 2'b10, "lw_after_rst"};
      do_req(hv);

`ifdef MEM_TIMEOUT_EN
      // Timeout: memory never completes, error after 8 WAIT cycles, then DRAIN.
      wait_idle("to");
      acc_dly = 0;
      hold    = 1'b1;
      start_req(1'b0, 3'b010, 32'h100, 32'h0);
      n = 0;
      while (memExecute && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("to_wait_entry", 32'(memExecute), 32'd0);
      n = 0;
      while (!respValid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("to_cycles", 32'(n), 32'd8);
      check("to_err", 32'(respErr), 32'd1);
      check("to_data", respData, 32'h0);
      repeat (3) begin
         @(negedge clk);
         check("to_drain_rdy", 32'(reqReady), 32'd0);
      end
      hold = 1'b0;
      n = 0;
      while (!reqReady && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("to_drain_exit", 32'(reqReady), 32'd1);
      hv = '{1'b0, 3'b010, 32'h300, 32'h0, 0, 1'b0, 32'h00005678, 1'b1, 2'b10, "lw_after_to"};
      do_req(hv);
`endif

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
CPU-side bus master (load/store unit) for the data-memory responder. Accepts one RISC-V load/store request at a time from the execute stage and translates funct3 into memSize/memSign. Drives the memExecute/memReady/dataReady handshake and returns the load data or an error to the pipeline. Sits between the core's execute stage and the memory block (RAM below 0x8000, LED/seven-segment register at 0x10000).

Parameters:
TIMEOUT_CYCLES, 64, maximum number of cycles spent in WAIT before an error response (used only with MEM_TIMEOUT_EN).
CNT_W, 8, width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  input  1  clock, all state changes on rising edge
reset  input  1  synchronous active-low reset: reset==0 at a rising edge resets the block
reqValid  input  1  pipeline request valid
reqReady  output  1  block can accept a request; equals (state==IDLE && reset==1)
reqWrite  input  1  1 = store, 0 = load
reqFunct3  input  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
reqAddress  input  32  byte address
reqData  input  32  store data, right-aligned
respValid  output  1  one-cycle pulse: request complete
respData  output  32  load result, already extended by memory; 0 for stores and errors
respErr  output  1  qualifies respValid: misaligned, illegal funct3 or timeout
memReady  input  1  memory idle/complete
dataReady  input  1  memory read data valid
memExecute  output  1  start transaction
memWrite  output  1  1 = write
memSize  output  2  00 byte, 01 half, 10 word
memSign  output  1  sign-extend load
memAddress  output  32  transaction address
outputData  input  32  read data from memory
inputData  output  32  write data to memory

Behaviour:
- Reset (reset==0 at clock edge): state=IDLE; memExecute, memWrite, memSign, respValid, respErr = 0; memSize=00; memAddress, inputData, respData = 0; timeout counter = 0. Reset mid-transaction abandons it and produces no response.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE: a request is accepted when reqValid && reqReady. On acceptance, latch the request:
  - memAddress <= reqAddress; memWrite <= reqWrite; memSize <= reqFunct3[1:0]; inputData <= reqData.
  - memSign <= ~reqFunct3[2] for loads; memSign = 0 for stores.
- Request checks at acceptance:
  - Illegal funct3: loads 011/110/111, stores 011..111.
  - Misaligned: half with addr[0]=1; word with addr[1:0]!=00.
  - Either condition -> RESP with err=1. No bus activity; memExecute stays 0.
  - Otherwise -> ISSUE with memExecute=1.
- ISSUE: hold memExecute=1 and all mem* outputs stable. When memReady==0 is sampled (transaction accepted): memExecute <= 0, go to WAIT. memExecute asserted while memory is not yet ready is legal; keep waiting. No timeout is applied in ISSUE.
- WAIT: all mem* outputs except memExecute stay stable, because memory reads memAddress/memWrite live.
  - Load completes when memReady==1 && dataReady==1: respData <= outputData.
  - Store completes when memReady==1: respData <= 0.
  - On completion -> RESP with err=0.
- RESP: respValid=1 for exactly one cycle, then IDLE. respErr and respData are valid only on that cycle.
- Latency:
  - Error response: respValid 1 cycle after acceptance.
  - Bus response: respValid 1 cycle after memReady completes.
  - Minimum load time, acceptance to respValid, is 6 cycles against the memory block.
- Back-to-back operation: the next request may be accepted in the IDLE cycle after RESP. memExecute is never high while state==IDLE.
- memReady already high on WAIT entry: WAIT must require having been entered from ISSUE, i.e. memReady was sampled 0. Do not accept a stale high memReady.
- reqFunct3 values are decoded only at acceptance; later changes on req* inputs are ignored.

Optional Feature:
MEM_TIMEOUT_EN.
- Defined:
  - The counter clears on WAIT entry and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without completion: respValid=1, respErr=1, respData=0, then go to DRAIN.
  - DRAIN waits until memReady==1 with memExecute=0, then goes to IDLE. reqReady=0 in DRAIN.
  - Completion and timeout on the same cycle: completion wins.
- Undefined: no counter and no DRAIN state; WAIT waits indefinitely.

Test Plan:
1. SW 0xDEADBEEF to 0x100, then LW 0x100 -> store gives respValid, err=0, respData=0; load gives respData=0xDEADBEEF.
2. SB 0x80 to 0x200, then LB 0x200 -> respData=0xFFFFFF80 with memSign=1; LBU 0x200 -> respData=0x00000080 with memSign=0.
3. LW at 0x102 and LH at 0x101 -> respValid 1 cycle after acceptance with err=1; memExecute never asserted.
4. SW 0x00000003 to 0x10000 -> store completes err=0 and LED register written; memExecute deasserts the cycle after memReady is sampled 0.
5. With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, memory model holds memReady=0 -> err response after 8 WAIT cycles; reqReady stays 0 until memReady=1; the next LW then completes normally.
6. Pull reset low during WAIT -> next cycle all outputs at reset values, reqReady=0 while low; after release the first request completes correctly.
